// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch : instruction-fetch stage of the five-stage pipeline.
//
// Owns the program counter. Fetches one instruction at a time over a req/ack
// instruction-memory port that may take any number of cycles to answer. The
// fetched instruction and its PC+4 are held for the IF/ID register, and
// branch/jump redirects from ID are accepted at any time.
//
// Ports
//   clk            in   1   pipeline clock
//   rst            in   1   asynchronous reset, active-high
//   stall          in   2   00 advance; 01/10 bubble into IF/ID, fetch holds;
//                           11 hold
//   branch_flag    in   1   redirect request from ID (single-cycle pulse)
//   branch_target  in  32   redirect PC, valid with branch_flag
//   imem_req       out  1   instruction-memory request
//   imem_addr      out 32   request address (current PC)
//   imem_ack       in   1   transfer complete, sampled only while imem_req=1
//   imem_rdata     in  32   instruction, valid with imem_ack
//   if_pc_plus4    out 32   PC+4 of the held instruction
//   if_inst        out 32   held instruction, NOP_INST when none is held
//   if_valid       out  1   held instruction is valid
//   stallreq_if    out  1   no instruction ready for IF/ID
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stallreq_if
);

  // State encoding is chosen so that imem_req and if_valid are each a single
  // state flop bit, keeping both outputs free of decode glitches.
  localparam logic [1:0] ST_START = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  localparam logic [1:0] STALL_ADVANCE = 2'b00;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt;
  logic [31:0] inst_r;
  logic [31:0] inst_nxt;
  logic [31:0] pc_plus4_r;
  logic [31:0] pc_plus4_nxt;
  logic        pend_r;
  logic        pend_nxt;
  logic [31:0] pend_target_r;
  logic [31:0] pend_target_nxt;
  logic [31:0] pc_inc;
  logic [31:0] branch_pc;

  // 32-bit modulo increment; 0xFFFF_FFFC wraps to 0.
  assign pc_inc    = pc_r + 32'd4;
  assign branch_pc = word_align(branch_target);

  // Next-state and datapath decisions for the fetch controller.
  always_comb begin
    state_nxt       = state_r;
    pc_nxt          = pc_r;
    inst_nxt        = inst_r;
    pc_plus4_nxt    = pc_plus4_r;
    pend_nxt        = pend_r;
    pend_target_nxt = pend_target_r;

    case (state_r)
      ST_START: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_ack) begin
          // The request completes this edge. A redirect seen now or while
          // waiting makes the returned word stale: drop it and refetch.
          if (branch_flag) begin
            pc_nxt   = branch_pc;
            pend_nxt = 1'b0;
          end else if (pend_r) begin
            pc_nxt   = pend_target_r;
            pend_nxt = 1'b0;
          end else begin
            inst_nxt     = imem_rdata;
            pc_plus4_nxt = pc_inc;
            state_nxt    = ST_READY;
          end
        end else if (branch_flag) begin
          // The bus request cannot be withdrawn, so remember where to go
          // once it completes. The newest redirect wins.
          pend_nxt        = 1'b1;
          pend_target_nxt = branch_pc;
        end else begin
          pend_nxt = pend_r;
        end
      end

      ST_READY: begin
        if (branch_flag) begin
          // Redirect beats any stall code: the held word is on the wrong path.
          pc_nxt       = branch_pc;
          inst_nxt     = NOP_INST;
          pc_plus4_nxt = 32'h0000_0000;
          state_nxt    = ST_FETCH;
        end else if (stall == STALL_ADVANCE) begin
          // IF/ID takes the instruction on this edge.
          pc_nxt       = pc_inc;
          inst_nxt     = NOP_INST;
          pc_plus4_nxt = 32'h0000_0000;
          state_nxt    = ST_FETCH;
        end else begin
          state_nxt = ST_READY;
        end
      end

      default: begin
        // Unreachable encoding: restart fetch from the current PC.
        inst_nxt     = NOP_INST;
        pc_plus4_nxt = 32'h0000_0000;
        pend_nxt     = 1'b0;
        state_nxt    = ST_START;
      end
    endcase
  end

  // Controller state and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_START;
      pc_r          <= RESET_PC;
      pend_r        <= 1'b0;
      pend_target_r <= RESET_PC;
    end else begin
      state_r       <= state_nxt;
      pc_r          <= pc_nxt;
      pend_r        <= pend_nxt;
      pend_target_r <= pend_target_nxt;
    end
  end

  // Held instruction and its PC+4, presented to IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_r     <= NOP_INST;
      pc_plus4_r <= 32'h0000_0000;
    end else begin
      inst_r     <= inst_nxt;
      pc_plus4_r <= pc_plus4_nxt;
    end
  end

  assign imem_req    = state_r[0];
  assign imem_addr   = pc_r;
  assign if_valid    = state_r[1];
  assign stallreq_if = ~state_r[1];
  assign if_inst     = inst_r;
  assign if_pc_plus4 = pc_plus4_r;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stallreq_if;

  int vectors = 0;
  int miscompares = 0;

  if_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc_plus4(if_pc_plus4),
    .if_inst(if_inst), .if_valid(if_valid), .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  // Behavioural model: "started" (first cycle after reset done), "have"
  // (an instruction is held), the PC, the held word, and a queue holding at
  // most one redirect target to apply when the outstanding fetch completes.
  bit          m_started;
  bit          m_have;
  logic [31:0] m_pc;
  logic [31:0] m_held;
  logic [31:0] m_held_pc4;
  logic [31:0] m_redir[$];

  function automatic logic [31:0] align(input logic [31:0] a);
    logic [31:0] r;
    r = a & 32'hFFFF_FFFC;
    return r;
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_have    = 1'b0;
    m_pc      = RESET_PC;
    m_held    = NOP_INST;
    m_held_pc4 = 32'h0;
    m_redir.delete();
  endtask

  task automatic model_update(input logic [1:0] s, input logic b, input logic [31:0] t,
                              input logic a, input logic [31:0] d);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_have) begin
      if (a) begin
        if (b) begin
          m_pc = align(t);
          m_redir.delete();
        end else if (m_redir.size() != 0) begin
          m_pc = m_redir.pop_front();
        end else begin
          m_have     = 1'b1;
          m_held     = d;
          m_held_pc4 = m_pc + 32'd4;
        end
      end else if (b) begin
        m_redir.delete();
        m_redir.push_back(align(t));
      end
    end else begin
      if (b) begin
        m_have = 1'b0;
        m_pc   = align(t);
      end else if (s == 2'b00) begin
        m_have = 1'b0;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    cmp("imem_req", {31'd0, imem_req}, {31'd0, (m_started && !m_have)});
    cmp("imem_addr", imem_addr, m_pc);
    cmp("if_valid", {31'd0, if_valid}, {31'd0, m_have});
    cmp("stallreq_if", {31'd0, stallreq_if}, {31'd0, !m_have});
    cmp("if_inst", if_inst, m_have ? m_held : NOP_INST);
    if (m_have) cmp("if_pc_plus4", if_pc_plus4, m_held_pc4);
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // check the outputs at the next falling edge.
  task automatic step(input logic [1:0] s, input logic b, input logic [31:0] t,
                      input logic a, input logic [31:0] d);
    stall = s; branch_flag = b; branch_target = t; imem_ack = a; imem_rdata = d;
    if (rst) model_reset();
    else model_update(s, b, t, a, d);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; stall = 2'b11; branch_flag = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    cmp("rst_req", {31'd0, imem_req}, 32'd0);
    cmp("rst_addr", imem_addr, 32'h0000_0000);
    cmp("rst_inst", if_inst, 32'h0000_0013);
    cmp("rst_pc4", if_pc_plus4, 32'h0000_0000);
    cmp("rst_stallreq", {31'd0, stallreq_if}, 32'd1);

    // Release and zero-wait fetch of 0x2408_0001.
    rst = 1'b0;
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'h2408_0001);
    cmp("first_req", {31'd0, imem_req}, 32'd1);
    cmp("first_addr", imem_addr, 32'h0);
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'h2408_0001);
    cmp("first_valid", {31'd0, if_valid}, 32'd1);
    cmp("first_inst", if_inst, 32'h2408_0001);
    cmp("first_pc4", if_pc_plus4, 32'h4);

    // Hold for three cycles, then advance.
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
      cmp("hold_inst", if_inst, 32'h2408_0001);
    end
    step(2'b00, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    cmp("adv_addr", imem_addr, 32'h4);
    cmp("adv_valid", {31'd0, if_valid}, 32'd0);
    cmp("adv_stallreq", {31'd0, stallreq_if}, 32'd1);

    // Three-cycle ack latency at 0x4.
    step(2'b00, 1'b0, 32'h0, 1'b0, 32'h1111_1111);
    step(2'b00, 1'b0, 32'h0, 1'b0, 32'h2222_2222);
    cmp("lat_addr", imem_addr, 32'h4);
    cmp("lat_stallreq", {31'd0, stallreq_if}, 32'd1);
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'hAAAA_0004);
    cmp("lat_inst", if_inst, 32'hAAAA_0004);
    cmp("lat_pc4", if_pc_plus4, 32'h8);

    // Redirect from READY to 0x10, fetch it, then branch to 0x40 with stall=00.
    step(2'b11, 1'b1, 32'h10, 1'b0, 32'h0);
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'h0000_0010);
    cmp("r10_pc4", if_pc_plus4, 32'h14);
    step(2'b00, 1'b1, 32'h40, 1'b0, 32'h0);
    cmp("br_addr", imem_addr, 32'h40);
    cmp("br_valid", {31'd0, if_valid}, 32'd0);
    cmp("br_inst", if_inst, NOP_INST);

    // Fetch 0x40, then branch to 0x20 and redirect while waiting.
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
    step(2'b11, 1'b1, 32'h20, 1'b0, 32'h0);
    step(2'b11, 1'b1, 32'h80, 1'b0, 32'h0);
    step(2'b11, 1'b0, 32'h0, 1'b0, 32'h0);
    cmp("pend_addr_hold", imem_addr, 32'h20);
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    cmp("pend_valid", {31'd0, if_valid}, 32'd0);
    cmp("pend_addr", imem_addr, 32'h80);
    step(2'b11, 1'b1, 32'h84, 1'b0, 32'h0);
    step(2'b11, 1'b1, 32'h90, 1'b0, 32'h0);
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    cmp("pend2_addr", imem_addr, 32'h90);
    // Same-cycle branch beats pending target; low bits forced to zero.
    step(2'b11, 1'b1, 32'hA0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 32'hB3, 1'b1, 32'hDEAD_BEEF);
    cmp("prio_addr", imem_addr, 32'hB0);

    // PC wrap at 0xFFFF_FFFC.
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'h0000_00B0);
    step(2'b11, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step(2'b11, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    cmp("wrap_pc4", if_pc_plus4, 32'h0);
    step(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    cmp("wrap_addr", imem_addr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
           $urandom, ($urandom_range(0, 2) == 0), $urandom);
    end

    // Reset asserted in the middle of an outstanding fetch.
    step(2'b00, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    cmp("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    cmp("async_req", {31'd0, imem_req}, 32'd0);
    cmp("async_addr", imem_addr, RESET_PC);
    cmp("async_valid", {31'd0, if_valid}, 32'd0);
    step(2'b00, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
    rst = 1'b0;
    step(2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
    cmp("rerun_addr", imem_addr, 32'h0);
    for (int i = 0; i < 200; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           $urandom, ($urandom_range(0, 1) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
